display_scheduler: RTL and testbench
====================================

// Module: display_scheduler
// PURPOSE
//  Owns the 3-digit FND: picks what the LED driver shows and how long. Arbitrates four sources:
//  error code > one-shot message > wait animation > current bubble page. Shows messages and
//  errors for a minimum hold time; errors stay on, blinking, until cleared. Sits between the
//  emulator/config logic and the display driver; drives the driver's 12-bit value and mode inputs.
// PARAMETERS
//  HOLD_CYCLES  24'd4_800_000  min display time of a message or error, in MCLK cycles (100 ms @48 MHz)
//  BLINK_BIT    23             bit of free-running counter used as error blink phase
// PORTS
//  MCLK        in   1   48 MHz clock
//  RST         in   1   synchronous reset, active-high
//  nWAIT       in   1   low = emulator waiting; selects wait animation in background
//  CURRPAGE    in   12  current page, background value
//  ERR_REQ     in   1   error display request, held high until ERR_ACK
//  ERR_CODE    in   8   error code; shown as {4'hE, ERR_CODE}
//  ERR_CLR     in   1   clear request for displayed error (level)
//  ERR_ACK     out  1   1-cycle pulse, error accepted and ERR_CODE captured
//  MSG_REQ     in   1   message request, held high until MSG_ACK
//  MSG_VALUE   in   12  three hex digits to show
//  MSG_ACK     out  1   1-cycle pulse, message accepted and MSG_VALUE captured
//  DISP_VALUE  out  12  digit values to driver
//  DISP_SEL    out  2   00 page, 01 wait anim, 10 message, 11 error
//  DISP_BLANK  out  1   1 = driver blanks all digits
//  BUSY        out  1   1 in MSG_HOLD or ERR_HOLD
// BEHAVIOUR
//  - All outputs registered. Reset: state BG, DISP_VALUE 0, DISP_SEL 00, DISP_BLANK 0, ACKs 0,
//    BUSY 0, hold timer 0, blink counter 0, clr_pend 0, both req-armed flags 1.
//  - States: BG (page/wait), MSG_HOLD, ERR_HOLD.
//  - BG: DISP_SEL = nWAIT ? 00 : 01; DISP_VALUE = CURRPAGE when 00, 0 when 01 (driver animates);
//    1-cycle latency from CURRPAGE/nWAIT to outputs.
//  - Request qualification: a REQ is accepted only while its armed flag is 1; accept clears the
//    flag; flag re-sets after REQ sampled low for >=1 cycle. REQ held high after ACK is NOT re-accepted.
//  - ERR accept (any state, armed): capture code, ERR_ACK=1 next cycle, -> ERR_HOLD, timer loads
//    HOLD_CYCLES-1, clr_pend cleared. New error during ERR_HOLD replaces code, restarts timer.
//  - MSG accept only in BG, armed, and ERR not accepted same cycle: capture, MSG_ACK=1,
//    -> MSG_HOLD, timer loads HOLD_CYCLES-1. MSG_REQ in MSG_HOLD/ERR_HOLD waits, not acked.
//  - Simultaneous ERR_REQ and MSG_REQ: ERR wins; MSG stays pending, served later from BG.
//  - MSG_HOLD: DISP_SEL 10, value = captured msg; timer decrements to 0; at 0 -> BG the next cycle
//    (a pending MSG_REQ is accepted from BG one cycle later). Display time = HOLD_CYCLES cycles.
//  - ERR_HOLD: DISP_SEL 11, value {4'hE, code}, DISP_BLANK = blink_cnt[BLINK_BIT]. ERR_CLR high
//    any cycle sets clr_pend. Exit to BG when timer == 0 and (clr_pend | ERR_CLR); early ERR_CLR
//    never shortens hold. DISP_BLANK 0 outside ERR_HOLD.
//  - Timer 24-bit, saturates at 0; HOLD_CYCLES = 0 treated as 1. Blink counter free-runs, wraps.
//  - RST mid-hold: abandon immediately to reset values; REQ still high after reset is accepted
//    in the first cycle after RST drops (armed flags reset to 1).
// TESTING  (HOLD_CYCLES=8, BLINK_BIT=2)
//  1 RST release, nWAIT=1, CURRPAGE=12'h2A5 -> next cycle DISP_SEL=00, DISP_VALUE=2A5; nWAIT=0 -> SEL=01.
//  2 MSG_REQ with 12'h1C0, held high -> one MSG_ACK pulse, SEL=10 for exactly 8 cycles, back to 00;
//    no second ACK until MSG_REQ drops and rises again.
//  3 ERR_REQ (code 8'h42) and MSG_REQ same cycle -> ERR_ACK only, value E42, BLANK toggles every
//    4 cycles; ERR_CLR at cycle 2 -> stays until timer 0, then BG; pending MSG then acked.
//  4 Second ERR_REQ (8'h07) at cycle 5 of ERR_HOLD -> ERR_ACK, value E07, hold restarts (8 more cycles).
//  5 RST asserted mid-MSG_HOLD with MSG_REQ still high -> all outputs reset; ACK 1 cycle after RST drops.
//  6 No ERR_CLR ever -> error stays displayed indefinitely (check 100 cycles), BUSY=1 throughout.

Source files
------------

// File: rtl/display_scheduler_if.sv
`timescale 1ns/1ps
// Scheduler-side bundle: request/ack pairs from emulator and config logic,
// plus the value/mode lines that feed the FND driver.
// Combinational wiring only; flow control is REQ held high until ACK.
interface display_scheduler_if;
  logic        nWAIT;
  logic [11:0] CURRPAGE;
  logic        ERR_REQ;
  logic [7:0]  ERR_CODE;
  logic        ERR_CLR;
  logic        ERR_ACK;
  logic        MSG_REQ;
  logic [11:0] MSG_VALUE;
  logic        MSG_ACK;
  logic [11:0] DISP_VALUE;
  logic [1:0]  DISP_SEL;
  logic        DISP_BLANK;
  logic        BUSY;

  modport master (
    output nWAIT, CURRPAGE, ERR_REQ, ERR_CODE, ERR_CLR, MSG_REQ, MSG_VALUE,
    input  ERR_ACK, MSG_ACK, DISP_VALUE, DISP_SEL, DISP_BLANK, BUSY
  );

  modport slave (
    input  nWAIT, CURRPAGE, ERR_REQ, ERR_CODE, ERR_CLR, MSG_REQ, MSG_VALUE,
    output ERR_ACK, MSG_ACK, DISP_VALUE, DISP_SEL, DISP_BLANK, BUSY
  );
endinterface

// File: rtl/display_scheduler.sv
`timescale 1ns/1ps
// Arbitrates error > message > wait animation > page onto the 3-digit FND.
// Latency: 1 cycle from any input to the registered outputs and ACK pulses.
// Backpressure: REQ stays high until ACK; busy holds defer messages, never errors.
module display_scheduler #(
  parameter logic [23:0] HOLD_CYCLES = 24'd4_800_000,
  parameter int          BLINK_BIT   = 23
) (
  input  logic              MCLK,
  input  logic              RST,
  display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {BG, MSG_HOLD, ERR_HOLD} state_t;

  // A zero hold is stretched to one cycle so each message is visible at least once.
  localparam logic [23:0] HOLD_LOAD = (HOLD_CYCLES == 24'd0) ? 24'd0 : HOLD_CYCLES - 24'd1;

  state_t             state;
  logic [23:0]        timer;
  logic [BLINK_BIT:0] blink_cnt;
  logic               clr_pend;
  logic               err_armed;
  logic               msg_armed;
  logic [7:0]         err_code;
  logic [11:0]        msg_val;

  logic               err_acc;
  logic               msg_acc;
  logic               timer_zero;
  logic [23:0]        timer_dec;
  logic [BLINK_BIT:0] blink_nxt;
  logic [11:0]        bg_value;
  logic [1:0]         bg_sel;
  logic               clr_now;

  always_comb begin
    err_acc    = bus.ERR_REQ & err_armed;
    msg_acc    = bus.MSG_REQ & msg_armed & (state == BG) & ~err_acc;
    timer_zero = (timer == 24'd0);
    timer_dec  = timer_zero ? 24'd0 : timer - 24'd1;
    blink_nxt  = blink_cnt + 1'b1;
    bg_value   = bus.nWAIT ? bus.CURRPAGE : 12'h000;
    bg_sel     = bus.nWAIT ? 2'b00 : 2'b01;
    clr_now    = clr_pend | bus.ERR_CLR;
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state          <= BG;
      timer          <= 24'd0;
      blink_cnt      <= '0;
      clr_pend       <= 1'b0;
      err_armed      <= 1'b1;
      msg_armed      <= 1'b1;
      err_code       <= 8'h00;
      msg_val        <= 12'h000;
      bus.ERR_ACK    <= 1'b0;
      bus.MSG_ACK    <= 1'b0;
      bus.DISP_VALUE <= 12'h000;
      bus.DISP_SEL   <= 2'b00;
      bus.DISP_BLANK <= 1'b0;
      bus.BUSY       <= 1'b0;
    end else begin
      blink_cnt   <= blink_nxt;
      bus.ERR_ACK <= err_acc;
      bus.MSG_ACK <= msg_acc;
      // A request re-arms only after it has been seen low once.
      err_armed   <= ~err_acc & (err_armed | ~bus.ERR_REQ);
      msg_armed   <= ~msg_acc & (msg_armed | ~bus.MSG_REQ);

      // Background view is the default; hold states override it below.
      bus.DISP_SEL   <= bg_sel;
      bus.DISP_VALUE <= bg_value;
      bus.DISP_BLANK <= 1'b0;
      bus.BUSY       <= 1'b0;

      if (err_acc) begin
        state          <= ERR_HOLD;
        err_code       <= bus.ERR_CODE;
        timer          <= HOLD_LOAD;
        clr_pend       <= 1'b0;
        bus.DISP_SEL   <= 2'b11;
        bus.DISP_VALUE <= {4'hE, bus.ERR_CODE};
        bus.DISP_BLANK <= blink_nxt[BLINK_BIT];
        bus.BUSY       <= 1'b1;
      end else if (msg_acc) begin
        state          <= MSG_HOLD;
        msg_val        <= bus.MSG_VALUE;
        timer          <= HOLD_LOAD;
        bus.DISP_SEL   <= 2'b10;
        bus.DISP_VALUE <= bus.MSG_VALUE;
        bus.BUSY       <= 1'b1;
      end else begin
        case (state)
          MSG_HOLD: begin
            if (timer_zero) begin
              state <= BG;
            end else begin
              timer          <= timer_dec;
              bus.DISP_SEL   <= 2'b10;
              bus.DISP_VALUE <= msg_val;
              bus.BUSY       <= 1'b1;
            end
          end
          ERR_HOLD: begin
            clr_pend <= clr_now;
            // An early clear is remembered but only acts once the hold has expired.
            if (timer_zero && clr_now) begin
              state <= BG;
            end else begin
              timer          <= timer_dec;
              bus.DISP_SEL   <= 2'b11;
              bus.DISP_VALUE <= {4'hE, err_code};
              bus.DISP_BLANK <= blink_nxt[BLINK_BIT];
              bus.BUSY       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench: a rule-level model predicts every output cycle and every ACK.
module tb_display_scheduler;

  localparam logic [23:0] HOLD = 24'd8;
  localparam int          BB   = 2;

  logic MCLK = 1'b0;
  logic RST  = 1'b1;

  display_scheduler_if bus();

  display_scheduler #(.HOLD_CYCLES(HOLD), .BLINK_BIT(BB)) dut (
    .MCLK (MCLK),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic [11:0] val;
    logic [1:0]  sel;
    logic        blank;
    logic        busy;
    logic        eack;
    logic        mack;
  } obs_t;

  obs_t        exp_q[$];
  logic [11:0] ack_e_q[$];
  logic [11:0] ack_m_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Model: mode 0 = background, 1 = message shown, 2 = error shown.
  // m_left counts display cycles still owed, including the current one.
  int          m_mode, m_left, m_blink;
  bit          m_clr, m_earm, m_marm;
  logic [7:0]  m_code;
  logic [11:0] m_msg;
  bit          last_eack, last_mack;

  task automatic model_step(output obs_t e);
    bit ae, am;
    e = '0;
    if (RST) begin
      m_mode = 0; m_left = 0; m_blink = 0; m_clr = 0;
      m_earm = 1; m_marm = 1; m_code = 8'h00; m_msg = 12'h000;
    end else begin
      m_blink = m_blink + 1;
      ae = bus.ERR_REQ && m_earm;
      am = bus.MSG_REQ && m_marm && (m_mode == 0) && !ae;
      if (ae) m_earm = 0; else if (!bus.ERR_REQ) m_earm = 1;
      if (am) m_marm = 0; else if (!bus.MSG_REQ) m_marm = 1;
      if (ae) begin
        m_mode = 2; m_left = int'(HOLD); m_clr = 0; m_code = bus.ERR_CODE;
        ack_e_q.push_back({4'hE, bus.ERR_CODE});
      end else if (am) begin
        m_mode = 1; m_left = int'(HOLD); m_msg = bus.MSG_VALUE;
        ack_m_q.push_back(bus.MSG_VALUE);
      end else if (m_mode == 1) begin
        if (m_left <= 1) m_mode = 0; else m_left = m_left - 1;
      end else if (m_mode == 2) begin
        m_clr = m_clr || bus.ERR_CLR;
        if (m_left <= 1 && m_clr) m_mode = 0;
        else if (m_left > 1) m_left = m_left - 1;
      end
      e.eack = ae;
      e.mack = am;
      case (m_mode)
        1: begin e.sel = 2'b10; e.val = m_msg; e.busy = 1'b1; end
        2: begin
          e.sel = 2'b11; e.val = {4'hE, m_code}; e.busy = 1'b1;
          e.blank = ((m_blink >> BB) & 1) != 0;
        end
        default: begin
          e.sel = bus.nWAIT ? 2'b00 : 2'b01;
          e.val = bus.nWAIT ? bus.CURRPAGE : 12'h000;
        end
      endcase
    end
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    obs_t e;
    model_step(e);
    exp_q.push_back(e);
    last_eack = e.eack;
    last_mack = e.mack;
    @(negedge MCLK);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin : monitor
    obs_t e, a;
    logic [11:0] v;
    forever begin
      @(posedge MCLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.val   = bus.DISP_VALUE;
        a.sel   = bus.DISP_SEL;
        a.blank = bus.DISP_BLANK;
        a.busy  = bus.BUSY;
        a.eack  = bus.ERR_ACK;
        a.mack  = bus.MSG_ACK;
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got val=%h sel=%b blank=%b busy=%b eack=%b mack=%b want val=%h sel=%b blank=%b busy=%b eack=%b mack=%b",
                   $time, a.val, a.sel, a.blank, a.busy, a.eack, a.mack,
                   e.val, e.sel, e.blank, e.busy, e.eack, e.mack);
        end
        if (a.eack === 1'b1) begin
          checks++;
          if (ack_e_q.size() == 0) begin
            failures++;
            $display("FAIL err_ack t=%0t got unexpected ack want none", $time);
          end else begin
            v = ack_e_q.pop_front();
            if (a.val !== v) begin
              failures++;
              $display("FAIL err_ack_value t=%0t got %h want %h", $time, a.val, v);
            end
          end
        end
        if (a.mack === 1'b1) begin
          checks++;
          if (ack_m_q.size() == 0) begin
            failures++;
            $display("FAIL msg_ack t=%0t got unexpected ack want none", $time);
          end else begin
            v = ack_m_q.pop_front();
            if (a.val !== v) begin
              failures++;
              $display("FAIL msg_ack_value t=%0t got %h want %h", $time, a.val, v);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench did not complete");
  end

  initial begin : stimulus
    bit err_acked, msg_acked;
    bus.nWAIT     = 1'b1;
    bus.CURRPAGE  = 12'h000;
    bus.ERR_REQ   = 1'b0;
    bus.ERR_CODE  = 8'h00;
    bus.ERR_CLR   = 1'b0;
    bus.MSG_REQ   = 1'b0;
    bus.MSG_VALUE = 12'h000;
    @(negedge MCLK);
    ticks(3);

    // Background page and wait animation
    RST = 1'b0; bus.CURRPAGE = 12'h2A5; ticks(3);
    bus.nWAIT = 1'b0; ticks(2);
    bus.nWAIT = 1'b1; bus.CURRPAGE = 12'h3FF; ticks(2);

    // Message held high: one ACK, 8-cycle hold, no re-accept until REQ cycles low
    bus.MSG_VALUE = 12'h1C0; bus.MSG_REQ = 1'b1; ticks(14);
    bus.MSG_REQ = 1'b0; tick();
    bus.MSG_VALUE = 12'h5D1; bus.MSG_REQ = 1'b1; ticks(2);
    bus.MSG_REQ = 1'b0; ticks(10);

    // Error and message together: error wins, message served afterwards
    bus.ERR_CODE = 8'h42; bus.ERR_REQ = 1'b1;
    bus.MSG_VALUE = 12'h3B7; bus.MSG_REQ = 1'b1; ticks(2);
    bus.ERR_REQ = 1'b0; bus.ERR_CLR = 1'b1; tick();
    bus.ERR_CLR = 1'b0; ticks(12);
    bus.MSG_REQ = 1'b0; ticks(10);

    // Second error mid-hold restarts the hold
    bus.ERR_CODE = 8'h55; bus.ERR_REQ = 1'b1; tick();
    bus.ERR_REQ = 1'b0; ticks(4);
    bus.ERR_CODE = 8'h07; bus.ERR_REQ = 1'b1; tick();
    bus.ERR_REQ = 1'b0; bus.ERR_CLR = 1'b1; ticks(11);
    bus.ERR_CLR = 1'b0; ticks(3);

    // Reset mid-message with REQ still high
    bus.MSG_VALUE = 12'hABC; bus.MSG_REQ = 1'b1; ticks(4);
    RST = 1'b1; ticks(2);
    RST = 1'b0; ticks(3);
    bus.MSG_REQ = 1'b0; ticks(10);

    // Uncleared error persists indefinitely
    bus.ERR_CODE = 8'h99; bus.ERR_REQ = 1'b1; tick();
    bus.ERR_REQ = 1'b0; ticks(100);
    bus.ERR_CLR = 1'b1; tick();
    bus.ERR_CLR = 1'b0; ticks(3);

    // Randomized traffic obeying the hold-until-ACK protocol
    err_acked = 0; msg_acked = 0;
    repeat (3000) begin
      if (last_eack) err_acked = 1;
      if (last_mack) msg_acked = 1;
      bus.nWAIT    = ($urandom_range(0, 9) != 0);
      bus.CURRPAGE = 12'($urandom);
      if (!bus.ERR_REQ) begin
        if ($urandom_range(0, 59) == 0) begin
          bus.ERR_REQ = 1'b1; bus.ERR_CODE = 8'($urandom); err_acked = 0;
        end
      end else if (err_acked && $urandom_range(0, 3) == 0) begin
        bus.ERR_REQ = 1'b0;
      end
      if (!bus.MSG_REQ) begin
        if ($urandom_range(0, 9) == 0) begin
          bus.MSG_REQ = 1'b1; bus.MSG_VALUE = 12'($urandom); msg_acked = 0;
        end
      end else if (msg_acked && $urandom_range(0, 3) == 0) begin
        bus.MSG_REQ = 1'b0;
      end
      bus.ERR_CLR = ($urandom_range(0, 15) == 0);
      RST = ($urandom_range(0, 399) == 0);
      if (RST) begin err_acked = 0; msg_acked = 0; end
      tick();
    end

    RST = 1'b0; bus.ERR_REQ = 1'b0; bus.MSG_REQ = 1'b0; bus.ERR_CLR = 1'b1;
    ticks(20);
    bus.ERR_CLR = 1'b0; ticks(2);

    checks++;
    if (exp_q.size() != 0 || ack_e_q.size() != 0 || ack_m_q.size() != 0) begin
      failures++;
      $display("FAIL drain got exp=%0d err_acks=%0d msg_acks=%0d pending want 0",
               exp_q.size(), ack_e_q.size(), ack_m_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
